wb_slot_scheduler: RTL

WB_SLOT_SCHEDULER -- requirements
Module: wb_slot_scheduler

---
 rtl/wb_slot_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/wb_slot_scheduler.sv
// Shared writeback-port scheduler: fixed-latency units reserve a future slot at
// issue; a variable-latency divider fills cycles that no reservation claims.
module wb_slot_scheduler #(
  parameter int MaxLat      = 4,
  parameter int TransIdBits = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  input  logic [3:0]             issue_lat_i,
  input  logic [TransIdBits-1:0] issue_trans_id_i,
  output logic                   issue_ready_o,
  input  logic                   var_req_i,
  input  logic [TransIdBits-1:0] var_trans_id_i,
  output logic                   var_gnt_o,
  output logic                   wb_valid_o,
  output logic [TransIdBits-1:0] wb_trans_id_o,
  output logic [1:0]             wb_src_o,
  output logic [3:0]             occupancy_o,
  output logic [15:0]            stall_cnt_o
);

  typedef struct packed {
    logic                   vld;
    logic [TransIdBits-1:0] id;
  } slot_t;

  localparam logic [1:0] SrcSlot = 2'd0;
  localparam logic [1:0] SrcL0   = 2'd1;
  localparam logic [1:0] SrcVar  = 2'd2;

  slot_t [MaxLat:0] res_q, res_d;
  logic             slot_busy, lat_ok, fire, fire_l0;
  logic [3:0]       occ_d;

  // Latencies beyond MaxLat have no slot; the guarded lookup keeps the index in range.
  always_comb begin
    slot_busy = 1'b0;
    for (int j = 0; j <= MaxLat; j++)
      if (issue_lat_i == 4'(j)) slot_busy = res_q[j].vld;
  end

  assign lat_ok        = int'(issue_lat_i) <= MaxLat;
  assign issue_ready_o = !rst_i && !flush_i && lat_ok && !slot_busy;
  assign fire          = issue_valid_i && issue_ready_o;
  assign fire_l0       = fire && (issue_lat_i == 4'd0);
  assign var_gnt_o     = var_req_i && !rst_i && !flush_i && !res_q[0].vld && !fire_l0;

  always_comb begin
    wb_valid_o    = 1'b0;
    wb_trans_id_o = '0;
    wb_src_o      = SrcSlot;
    if (rst_i || flush_i) begin
      wb_valid_o = 1'b0;
    end else if (res_q[0].vld) begin
      wb_valid_o    = 1'b1;
      wb_trans_id_o = res_q[0].id;
      wb_src_o      = SrcSlot;
    end else if (fire_l0) begin
      wb_valid_o    = 1'b1;
      wb_trans_id_o = issue_trans_id_i;
      wb_src_o      = SrcL0;
    end else if (var_gnt_o) begin
      wb_valid_o    = 1'b1;
      wb_trans_id_o = var_trans_id_i;
      wb_src_o      = SrcVar;
    end
  end

  // Slot L-1 after the shift is the old slot L, which the ready check found free.
  always_comb begin
    res_d = '0;
    for (int j = 0; j < MaxLat; j++) res_d[j] = res_q[j+1];
    if (fire && issue_lat_i != 4'd0) begin
      for (int j = 0; j < MaxLat; j++)
        if (issue_lat_i == 4'(j + 1)) begin
          res_d[j].vld = 1'b1;
          res_d[j].id  = issue_trans_id_i;
        end
    end
    if (flush_i) res_d = '0;
    occ_d = '0;
    for (int j = 0; j <= MaxLat; j++) occ_d = occ_d + 4'(res_d[j].vld);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q       <= '0;
      occupancy_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      res_q       <= res_d;
      occupancy_o <= occ_d;
      if (issue_valid_i && !issue_ready_o && stall_cnt_o != 16'hFFFF)
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule
